sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
- Parametrised single-clock FIFO. It is the next-generation counterpart of the team's dual-clock FIFO, for datapaths where producer and consumer share one clock.
- Generalised data width and non-power-of-two depth.
- Adds capability the dual-clock FIFO lacks: fill count, programmable almost-full/almost-empty thresholds, selectable first-word-fall-through (FWFT) read mode, synchronous flush, and sticky overflow/underflow error flags.
- Sits between the UART/packet front-end and downstream consumers.

Parameters:
- DATASIZE, 8, data word width in bits.
- DEPTH, 90, number of storage entries; any integer >= 2, not restricted to powers of two.
- AFULL_THRESH, 80, o_almost_full asserts when count >= this value; legal range 1..DEPTH.
- AEMPTY_THRESH, 8, o_almost_empty asserts when count <= this value; legal range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- Derived constants:
  - ADDRSIZE = clog2(DEPTH)
  - CNTSIZE = clog2(DEPTH+1)

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request.
- wr_data  input  DATASIZE  write data.
- rd_en  input  1  read request.
- flush  input  1  synchronous clear of FIFO contents.
- clr_err  input  1  synchronous clear of the sticky error flags.
- rd_data  output  DATASIZE  read data.
- o_rd_valid  output  1  rd_data is valid.
- o_fifo_full  output  1  count == DEPTH.
- o_fifo_empty  output  1  count == 0.
- o_almost_full  output  1  count >= AFULL_THRESH.
- o_almost_empty  output  1  count <= AEMPTY_THRESH.
- o_count  output  CNTSIZE  current number of stored entries.
- o_overflow  output  1  sticky: a write was attempted while full.
- o_underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (asynchronous, rst=1) sets:
  - write pointer = 0, read pointer = 0, count = 0
  - o_fifo_empty = 1, o_fifo_full = 0
  - o_almost_empty = 1, o_almost_full = 0
  - o_overflow = 0, o_underflow = 0
  - rd_data = 0 (FWFT=0), o_rd_valid = 0
  - Memory contents are not reset.
- Accept rules:
  - A write is accepted iff wr_en && !o_fifo_full.
  - A read is accepted iff rd_en && !o_fifo_empty.
  - Both rules are evaluated on the flags at the start of the cycle.
  - When full, a write is rejected even if a read is accepted in the same cycle.
- Pointers:
  - Binary, 0..DEPTH-1.
  - On an accepted access, pointer == DEPTH-1 wraps to 0. There is no power-of-two wrap.
  - Full/empty are derived from count, not from pointer MSBs.
- Count update, one cycle after the event:
  - +1 on write only, -1 on read only.
  - Unchanged on simultaneous accepted read and write.
- Flags are registered alongside count. They are never combinational from wr_en or rd_en.
- Simultaneous read and write when 0 < count < DEPTH: both are accepted, count is unchanged, and both pointers advance.
- Simultaneous read and write when empty:
  - The write is accepted and the read is rejected.
  - o_underflow is set and count becomes 1.
  - No write-to-read bypass.
- FWFT=0 (registered read):
  - An accepted read in cycle N gives rd_data = mem[rptr] and o_rd_valid = 1 in cycle N+1.
  - o_rd_valid is a single-cycle pulse per accepted read.
  - rd_data holds its last value otherwise.
- FWFT=1 (first-word-fall-through):
  - o_rd_valid = !o_fifo_empty.
  - rd_data = mem[rptr] (head entry) whenever o_rd_valid = 1.
  - An accepted rd_en pops the head, and the next entry is presented the following cycle.
  - A word written into an empty FIFO is visible one cycle after the write.
- Flush:
  - Pointers and count go to 0; full, empty and almost-flag values return to their reset values; o_rd_valid = 0.
  - Flush has priority over wr_en and rd_en in the same cycle; those requests are dropped and do not set the error flags.
  - Error flags are unaffected by flush.
- Error flags:
  - o_overflow is set on wr_en && o_fifo_full; o_underflow is set on rd_en && o_fifo_empty.
  - Both hold until clr_err or rst.
  - If set and clear occur in the same cycle, set wins.
- Almost flags:
  - Compare the next count value and are registered, so they align with o_count.

Decomposition:
- Shared package fifo_pkg holds:
  - a clog2 function
  - the FWFT_OFF and FWFT_ON mode constants
  - the parameter-legality assertion macros (DEPTH >= 2, threshold ranges).
- One sub-module, fifo_ram: simple dual-port RAM, DATASIZE x DEPTH.
  - Synchronous write.
  - Read port selectable as registered (FWFT=0) or asynchronous (FWFT=1).
  - Shared with future FIFO variants.
- Pointer, count and flag logic lives in the top module.

Test Plan (DEPTH=90, AFULL_THRESH=80, AEMPTY_THRESH=8 unless stated):
- Reset, then 90 consecutive writes of 0x00..0x59 -> o_almost_empty deasserts after the 9th write; o_almost_full asserts when count reaches 80; o_fifo_full asserts with o_count=90; a 91st write sets o_overflow and o_count stays 90.
- From full, 90 reads with FWFT=0 -> rd_data sequence 0x00..0x59, each one cycle after rd_en; o_fifo_empty=1 after the last read; an extra rd_en sets o_underflow; clr_err clears both errors.
- Wrap test: write 60, read 60, then write 60 -> write pointer wraps from 89 to 0 at the 91st total write; all data reads back in order; count is never corrupted.
- Simultaneous wr_en+rd_en for 200 cycles at count=45 -> o_count constant at 45, no flag toggles; the same stimulus when empty -> count 0->1 and o_underflow=1.
- FWFT=1: write 0xA5 into an empty FIFO -> next cycle o_rd_valid=1, rd_data=0xA5 without rd_en; rd_en pops it and o_fifo_empty=1.
- Flush asserted together with wr_en at count=50, then rst pulsed mid-stream -> after flush o_count=0, o_fifo_empty=1, no new entry, error flags unchanged; after rst all outputs are at their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: sizing helper, read-mode
// constants and parameter-legality guards used at elaboration time.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

// Elaboration-time guard: the labelled error block exists only when the
// condition is false, so a legal parameter set produces no hardware.
`define FIFO_CHECK_PARAM(label, cond, msg) \
    if (!(cond)) begin : label \
        $error(msg); \
    end

`define FIFO_CHECK_DEPTH(depth) \
    `FIFO_CHECK_PARAM(g_bad_depth, ((depth) >= 2), "fifo: DEPTH must be >= 2")

`define FIFO_CHECK_THRESH(depth, afull, aempty) \
    `FIFO_CHECK_PARAM(g_bad_afull, (((afull) >= 1) && ((afull) <= (depth))), "fifo: AFULL_THRESH out of range") \
    `FIFO_CHECK_PARAM(g_bad_aempty, (((aempty) >= 0) && ((aempty) <= ((depth) - 1))), "fifo: AEMPTY_THRESH out of range")

package fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Number of bits needed to encode values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

`endif

// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle between a producer/consumer and the FIFO.
interface sync_fifo_flags_if
    import fifo_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int DEPTH    = 90
);
    localparam int CNTSIZE = clog2(DEPTH + 1);

    logic                wr_en;
    logic [DATASIZE-1:0] wr_data;
    logic                rd_en;
    logic                flush;
    logic                clr_err;
    logic [DATASIZE-1:0] rd_data;
    logic                o_rd_valid;
    logic                o_fifo_full;
    logic                o_fifo_empty;
    logic                o_almost_full;
    logic                o_almost_empty;
    logic [CNTSIZE-1:0]  o_count;
    logic                o_overflow;
    logic                o_underflow;

    modport master (
        output wr_en, wr_data, rd_en, flush, clr_err,
        input  rd_data, o_rd_valid, o_fifo_full, o_fifo_empty,
               o_almost_full, o_almost_empty, o_count, o_overflow, o_underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, flush, clr_err,
        output rd_data, o_rd_valid, o_fifo_full, o_fifo_empty,
               o_almost_full, o_almost_empty, o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: synchronous write, read port either registered
// (resettable output register) or asynchronous for fall-through use.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int DEPTH    = 90,
    parameter int FWFT     = FWFT_OFF,
    localparam int ADDRSIZE = clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDRSIZE-1:0] wr_addr,
    input  logic [DATASIZE-1:0] wr_data,
    input  logic                rd_en,
    input  logic [ADDRSIZE-1:0] rd_addr,
    output logic [DATASIZE-1:0] rd_data
);

    logic [DATASIZE-1:0] mem [DEPTH];

    // Storage write; contents deliberately not reset so it maps to RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (FWFT == FWFT_ON) begin : g_async_read
            assign rd_data = mem[rd_addr];
        end else begin : g_reg_read
            logic [DATASIZE-1:0] rd_q;

            // Registered read: capture the addressed word on a read, hold otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_q <= '0;
                end else if (rd_en) begin
                    rd_q <= mem[rd_addr];
                end
            end

            assign rd_data = rd_q;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, almost-full/empty thresholds,
// optional first-word-fall-through, synchronous flush and sticky errors.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATASIZE      = 8,
    parameter int DEPTH         = 90,
    parameter int AFULL_THRESH  = 80,
    parameter int AEMPTY_THRESH = 8,
    parameter int FWFT          = FWFT_OFF
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_flags_if.slave   bus
);

    localparam int ADDRSIZE = clog2(DEPTH);
    localparam int CNTSIZE  = clog2(DEPTH + 1);

    `FIFO_CHECK_DEPTH(DEPTH)
    `FIFO_CHECK_THRESH(DEPTH, AFULL_THRESH, AEMPTY_THRESH)

    logic [ADDRSIZE-1:0] wptr, rptr, wptr_next, rptr_next;
    logic [CNTSIZE-1:0]  count, count_next;
    logic                full_q, empty_q, afull_q, aempty_q;
    logic                overflow_q, underflow_q, valid_q;
    logic                wr_acc, rd_acc;

    // Pointers wrap explicitly at DEPTH-1, independent of power-of-two sizing.
    function automatic logic [ADDRSIZE-1:0] next_ptr(input logic [ADDRSIZE-1:0] ptr);
        if (ptr == ADDRSIZE'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    // Accept decisions from registered flags; next pointers and count.
    always_comb begin
        wr_acc     = bus.wr_en && !full_q && !bus.flush;
        rd_acc     = bus.rd_en && !empty_q && !bus.flush;
        wptr_next  = wptr;
        rptr_next  = rptr;
        count_next = count;
        if (bus.flush) begin
            wptr_next  = '0;
            rptr_next  = '0;
            count_next = '0;
        end else begin
            if (wr_acc) begin
                wptr_next = next_ptr(wptr);
            end
            if (rd_acc) begin
                rptr_next = next_ptr(rptr);
            end
            if (wr_acc && !rd_acc) begin
                count_next = count + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count_next = count - 1'b1;
            end
        end
    end

    // Pointer, count and status flags, all registered from the next count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            wptr     <= wptr_next;
            rptr     <= rptr_next;
            count    <= count_next;
            full_q   <= (count_next == CNTSIZE'(DEPTH));
            empty_q  <= (count_next == '0);
            afull_q  <= (count_next >= CNTSIZE'(AFULL_THRESH));
            aempty_q <= (count_next <= CNTSIZE'(AEMPTY_THRESH));
            valid_q  <= rd_acc;
        end
    end

    // Sticky error flags; a new error outranks clr_err, flushed requests are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_en && full_q && !bus.flush) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_q <= 1'b0;
            end
            if (bus.rd_en && empty_q && !bus.flush) begin
                underflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .DATASIZE (DATASIZE),
        .DEPTH    (DEPTH),
        .FWFT     (FWFT)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wptr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rptr),
        .rd_data (bus.rd_data)
    );

    generate
        if (FWFT == FWFT_ON) begin : g_fwft_valid
            assign bus.o_rd_valid = !empty_q;
        end else begin : g_reg_valid
            assign bus.o_rd_valid = valid_q;
        end
    endgenerate

    assign bus.o_fifo_full    = full_q;
    assign bus.o_fifo_empty   = empty_q;
    assign bus.o_almost_full  = afull_q;
    assign bus.o_almost_empty = aempty_q;
    assign bus.o_count        = count;
    assign bus.o_overflow     = overflow_q;
    assign bus.o_underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags: one registered-read
// instance (u0) and one fall-through instance (u1).
module tb_sync_fifo_flags;
    import fifo_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    sync_fifo_flags_if #(.DATASIZE(8), .DEPTH(90)) bus0 ();
    sync_fifo_flags_if #(.DATASIZE(8), .DEPTH(90)) bus1 ();

    sync_fifo_flags #(
        .DATASIZE(8), .DEPTH(90), .AFULL_THRESH(80), .AEMPTY_THRESH(8), .FWFT(FWFT_OFF)
    ) u0 (.clk(clk), .rst(rst), .bus(bus0));

    sync_fifo_flags #(
        .DATASIZE(8), .DEPTH(90), .AFULL_THRESH(80), .AEMPTY_THRESH(8), .FWFT(FWFT_ON)
    ) u1 (.clk(clk), .rst(rst), .bus(bus1));

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset away from the clock edge and release it.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    // Reset values must appear while reset is held, before any clock edge.
    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if ({bus0.o_fifo_empty, bus0.o_fifo_full, bus0.o_almost_empty, bus0.o_almost_full} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 1010",
                     {bus0.o_fifo_empty, bus0.o_fifo_full, bus0.o_almost_empty, bus0.o_almost_full});
        end
        checks++;
        if ({bus0.o_overflow, bus0.o_underflow, bus0.o_rd_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_err_valid: got %b expected 000",
                     {bus0.o_overflow, bus0.o_underflow, bus0.o_rd_valid});
        end
        checks++;
        if (bus0.o_count !== 7'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", bus0.o_count);
        end
        checks++;
        if (bus0.rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd_data: got %0h expected 0", bus0.rd_data);
        end
        checks++;
        if (bus1.o_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_fwft_valid: got %b expected 0", bus1.o_rd_valid);
        end
        #8;
        rst = 1'b0;
        tick();
    endtask

    // Fill to full, watching every threshold crossing, then overflow.
    task automatic test_fill();
        for (int i = 0; i < 90; i++) begin
            bus0.wr_en   = 1'b1;
            bus0.wr_data = 8'(i);
            tick();
            checks++;
            if (bus0.o_count !== 7'(i + 1)) begin
                errors++;
                $display("FAIL fill_count[%0d]: got %0d expected %0d", i, bus0.o_count, i + 1);
            end
            checks++;
            if (bus0.o_almost_empty !== ((i + 1) <= 8)) begin
                errors++;
                $display("FAIL fill_aempty[%0d]: got %b expected %b", i, bus0.o_almost_empty, (i + 1) <= 8);
            end
            checks++;
            if (bus0.o_almost_full !== ((i + 1) >= 80)) begin
                errors++;
                $display("FAIL fill_afull[%0d]: got %b expected %b", i, bus0.o_almost_full, (i + 1) >= 80);
            end
            checks++;
            if (bus0.o_fifo_full !== ((i + 1) == 90)) begin
                errors++;
                $display("FAIL fill_full[%0d]: got %b expected %b", i, bus0.o_fifo_full, (i + 1) == 90);
            end
        end
        bus0.wr_data = 8'hEE;
        tick();
        bus0.wr_en = 1'b0;
        checks++;
        if ({bus0.o_overflow, bus0.o_count} !== {1'b1, 7'd90}) begin
            errors++;
            $display("FAIL overflow: got ov=%b count=%0d expected ov=1 count=90", bus0.o_overflow, bus0.o_count);
        end
    endtask

    // Drain in registered-read mode, then underflow and clear both errors.
    task automatic test_drain();
        for (int i = 0; i < 90; i++) begin
            bus0.rd_en = 1'b1;
            tick();
            checks++;
            if ({bus0.o_rd_valid, bus0.rd_data} !== {1'b1, 8'(i)}) begin
                errors++;
                $display("FAIL drain_data[%0d]: got valid=%b data=%0h expected valid=1 data=%0h",
                         i, bus0.o_rd_valid, bus0.rd_data, i);
            end
            checks++;
            if (bus0.o_count !== 7'(89 - i)) begin
                errors++;
                $display("FAIL drain_count[%0d]: got %0d expected %0d", i, bus0.o_count, 89 - i);
            end
        end
        bus0.rd_en = 1'b0;
        tick();
        checks++;
        if ({bus0.o_fifo_empty, bus0.o_rd_valid, bus0.rd_data} !== {2'b10, 8'h59}) begin
            errors++;
            $display("FAIL drain_end: got empty=%b valid=%b data=%0h expected empty=1 valid=0 data=59",
                     bus0.o_fifo_empty, bus0.o_rd_valid, bus0.rd_data);
        end
        bus0.rd_en = 1'b1;
        tick();
        bus0.rd_en = 1'b0;
        checks++;
        if ({bus0.o_overflow, bus0.o_underflow, bus0.o_rd_valid} !== 3'b110) begin
            errors++;
            $display("FAIL underflow: got ov/un/valid=%b expected 110",
                     {bus0.o_overflow, bus0.o_underflow, bus0.o_rd_valid});
        end
        bus0.clr_err = 1'b1;
        tick();
        bus0.clr_err = 1'b0;
        checks++;
        if ({bus0.o_overflow, bus0.o_underflow} !== 2'b00) begin
            errors++;
            $display("FAIL clr_err: got ov/un=%b expected 00", {bus0.o_overflow, bus0.o_underflow});
        end
    endtask

    // Write 60 / read 60 / write 60 / read 60 from reset: write pointer wraps.
    task automatic test_wrap();
        int wr_idx;
        int rd_idx;
        pulse_reset();
        wr_idx = 0;
        rd_idx = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 60; i++) begin
                bus0.wr_en   = 1'b1;
                bus0.wr_data = 8'(wr_idx) ^ 8'hC3;
                wr_idx++;
                tick();
            end
            bus0.wr_en = 1'b0;
            checks++;
            if (bus0.o_count !== 7'd60) begin
                errors++;
                $display("FAIL wrap_count_full[%0d]: got %0d expected 60", pass, bus0.o_count);
            end
            for (int i = 0; i < 60; i++) begin
                bus0.rd_en = 1'b1;
                tick();
                checks++;
                if (bus0.rd_data !== (8'(rd_idx) ^ 8'hC3)) begin
                    errors++;
                    $display("FAIL wrap_data[%0d]: got %0h expected %0h", rd_idx, bus0.rd_data, 8'(rd_idx) ^ 8'hC3);
                end
                rd_idx++;
            end
            bus0.rd_en = 1'b0;
            checks++;
            if ({bus0.o_count, bus0.o_fifo_empty} !== {7'd0, 1'b1}) begin
                errors++;
                $display("FAIL wrap_empty[%0d]: got count=%0d empty=%b expected 0/1",
                         pass, bus0.o_count, bus0.o_fifo_empty);
            end
        end
    endtask

    // Simultaneous read+write at mid-fill holds count; on empty only the write lands.
    task automatic test_back_to_back();
        pulse_reset();
        for (int i = 0; i < 45; i++) begin
            bus0.wr_en   = 1'b1;
            bus0.wr_data = 8'(i + 1);
            tick();
        end
        bus0.rd_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            bus0.wr_data = 8'(i + 100);
            tick();
            checks++;
            if (bus0.o_count !== 7'd45) begin
                errors++;
                $display("FAIL b2b_count[%0d]: got %0d expected 45", i, bus0.o_count);
            end
            checks++;
            if ({bus0.o_fifo_full, bus0.o_fifo_empty, bus0.o_almost_full, bus0.o_almost_empty,
                 bus0.o_overflow, bus0.o_underflow, bus0.o_rd_valid} !== 7'b0000001) begin
                errors++;
                $display("FAIL b2b_flags[%0d]: got %b expected 0000001", i,
                         {bus0.o_fifo_full, bus0.o_fifo_empty, bus0.o_almost_full, bus0.o_almost_empty,
                          bus0.o_overflow, bus0.o_underflow, bus0.o_rd_valid});
            end
        end
        bus0.wr_en = 1'b0;
        bus0.rd_en = 1'b0;
        pulse_reset();
        bus0.wr_en = 1'b1;
        bus0.rd_en = 1'b1;
        tick();
        bus0.wr_en = 1'b0;
        bus0.rd_en = 1'b0;
        checks++;
        if ({bus0.o_count, bus0.o_underflow, bus0.o_rd_valid} !== {7'd1, 2'b10}) begin
            errors++;
            $display("FAIL b2b_empty: got count=%0d un=%b valid=%b expected 1/1/0",
                     bus0.o_count, bus0.o_underflow, bus0.o_rd_valid);
        end
    endtask

    // Fall-through instance: head word visible without a read request.
    task automatic test_fwft();
        checks++;
        if (bus1.o_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwft_idle_valid: got %b expected 0", bus1.o_rd_valid);
        end
        bus1.wr_en   = 1'b1;
        bus1.wr_data = 8'hA5;
        tick();
        bus1.wr_en = 1'b0;
        checks++;
        if ({bus1.o_rd_valid, bus1.rd_data, bus1.o_fifo_empty} !== {1'b1, 8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL fwft_show: got valid=%b data=%0h empty=%b expected 1/a5/0",
                     bus1.o_rd_valid, bus1.rd_data, bus1.o_fifo_empty);
        end
        bus1.rd_en = 1'b1;
        tick();
        bus1.rd_en = 1'b0;
        checks++;
        if ({bus1.o_rd_valid, bus1.o_fifo_empty, bus1.o_underflow} !== 3'b010) begin
            errors++;
            $display("FAIL fwft_pop: got valid/empty/un=%b expected 010",
                     {bus1.o_rd_valid, bus1.o_fifo_empty, bus1.o_underflow});
        end
        bus1.wr_en   = 1'b1;
        bus1.wr_data = 8'h11;
        tick();
        bus1.wr_data = 8'h22;
        tick();
        bus1.wr_en = 1'b0;
        checks++;
        if (bus1.rd_data !== 8'h11) begin
            errors++;
            $display("FAIL fwft_head: got %0h expected 11", bus1.rd_data);
        end
        bus1.rd_en = 1'b1;
        tick();
        bus1.rd_en = 1'b0;
        checks++;
        if ({bus1.o_rd_valid, bus1.rd_data, bus1.o_count} !== {1'b1, 8'h22, 7'd1}) begin
            errors++;
            $display("FAIL fwft_next: got valid=%b data=%0h count=%0d expected 1/22/1",
                     bus1.o_rd_valid, bus1.rd_data, bus1.o_count);
        end
    endtask

    // Flush beats a same-cycle write and keeps errors; reset acts asynchronously.
    task automatic test_flush_reset();
        pulse_reset();
        bus0.rd_en = 1'b1;
        tick();
        bus0.rd_en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            bus0.wr_en   = 1'b1;
            bus0.wr_data = 8'(i);
            tick();
        end
        bus0.flush = 1'b1;
        tick();
        bus0.flush = 1'b0;
        bus0.wr_en = 1'b0;
        checks++;
        if ({bus0.o_count, bus0.o_fifo_empty, bus0.o_almost_empty, bus0.o_almost_full, bus0.o_rd_valid}
            !== {7'd0, 4'b1100}) begin
            errors++;
            $display("FAIL flush_state: got count=%0d empty=%b ae=%b af=%b valid=%b expected 0/1/1/0/0",
                     bus0.o_count, bus0.o_fifo_empty, bus0.o_almost_empty, bus0.o_almost_full, bus0.o_rd_valid);
        end
        checks++;
        if ({bus0.o_overflow, bus0.o_underflow} !== 2'b01) begin
            errors++;
            $display("FAIL flush_errors: got ov/un=%b expected 01", {bus0.o_overflow, bus0.o_underflow});
        end
        tick();
        checks++;
        if (bus0.o_count !== 7'd0) begin
            errors++;
            $display("FAIL flush_no_entry: got %0d expected 0", bus0.o_count);
        end
        bus0.clr_err = 1'b1;
        tick();
        bus0.clr_err = 1'b0;
        bus0.flush   = 1'b1;
        bus0.rd_en   = 1'b1;
        tick();
        bus0.flush = 1'b0;
        bus0.rd_en = 1'b0;
        checks++;
        if (bus0.o_underflow !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop_read: got un=%b expected 0", bus0.o_underflow);
        end
        for (int i = 0; i < 5; i++) begin
            bus0.wr_en   = 1'b1;
            bus0.wr_data = 8'(i + 7);
            tick();
        end
        bus0.wr_en = 1'b0;
        bus0.rd_en = 1'b1;
        tick();
        bus0.rd_en = 1'b0;
        bus0.wr_en = 1'b1;
        tick();
        bus0.wr_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus0.o_count, bus0.o_fifo_empty, bus0.o_almost_empty, bus0.o_rd_valid, bus0.rd_data}
            !== {7'd0, 3'b110, 8'h00}) begin
            errors++;
            $display("FAIL async_reset: got count=%0d empty=%b ae=%b valid=%b data=%0h expected 0/1/1/0/0",
                     bus0.o_count, bus0.o_fifo_empty, bus0.o_almost_empty, bus0.o_rd_valid, bus0.rd_data);
        end
        #2;
        rst = 1'b0;
        tick();
    endtask

    // Sequence of directed scenarios, then the summary line.
    initial begin
        errors = 0;
        checks = 0;
        {bus0.wr_en, bus0.rd_en, bus0.flush, bus0.clr_err} = 4'b0000;
        {bus1.wr_en, bus1.rd_en, bus1.flush, bus1.clr_err} = 4'b0000;
        bus0.wr_data = 8'h00;
        bus1.wr_data = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_back_to_back();
        test_fwft();
        test_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
